// File: rtl/seq_divider64.sv
// 64-bit unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits straight to DONE with all-ones quotient.
module seq_divider64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        div_zero,
    output logic        zero,
    output logic        negative
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [63:0] dvsr_q;
    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [6:0]  cnt_q;

    logic [64:0] sh_rem;
    logic [65:0] trial;
    logic        fits;
    logic [63:0] rem_nxt;
    logic [63:0] quo_nxt;

    // rem < divisor always holds, so a successful trial fits back in 64 bits.
    always_comb begin
        sh_rem  = {rem_q, quo_q[63]};
        trial   = {1'b0, sh_rem} - {2'b00, dvsr_q};
        fits    = ~trial[65];
        rem_nxt = fits ? trial[63:0] : sh_rem[63:0];
        quo_nxt = {quo_q[62:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            dvsr_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                    if (start) begin
                        dvsr_q <= divisor;
                        quo_q  <= dividend;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        if (divisor == '0) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == 7'd63) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_nxt;
                        remainder <= rem_nxt;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign zero     = (quotient == '0);
    assign negative = quotient[63];

endmodule

// File: tb/tb_seq_divider64.sv
// Bench for seq_divider64: directed cases plus randomized traffic checked every
// cycle against a latency/arithmetic model of the divider.
module tb_seq_divider64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_zero;
    logic        zero;
    logic        negative;

    seq_divider64 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .zero      (zero),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: an accepted nonzero division finishes 64 edges later with a/b, a%b.
    logic [63:0] m_q, m_r, p_q, p_r;
    logic        m_busy, m_done, m_dz;
    int          left;

    always @(posedge clk) begin
        if (!reset) begin
            left   <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
        end else if (left > 0) begin
            left   <= left - 1;
            m_done <= (left == 1);
            m_busy <= (left > 1);
            if (left == 1) begin
                m_q  <= p_q;
                m_r  <= p_r;
                m_dz <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            if (start) begin
                if (divisor == '0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= dividend;
                    m_dz   <= 1'b1;
                end else begin
                    left   <= 64;
                    m_busy <= 1'b1;
                    p_q    <= dividend / divisor;
                    p_r    <= dividend % divisor;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("m_busy", {63'd0, busy}, {63'd0, m_busy});
                chk("m_done", {63'd0, done}, {63'd0, m_done});
                chk("m_quotient", quotient, m_q);
                chk("m_remainder", remainder, m_r);
                chk("m_div_zero", {63'd0, div_zero}, {63'd0, m_dz});
                chk("m_zero", {63'd0, zero}, {63'd0, (m_q == '0)});
                chk("m_negative", {63'd0, negative}, {63'd0, m_q[63]});
            end
        end
    end

    task automatic wait_done(input int t0, output int lat);
        while (!done && (cyc - t0) < 200) begin
            @(posedge clk);
            #1;
        end
        if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
        lat = cyc - t0;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, output int lat);
        int t0;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
        wait_done(t0, lat);
    endtask

    function automatic logic [63:0] rnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, 63);
    endfunction

    initial begin
        int lat;
        int t0;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd1);
        chk("rst_negative", {63'd0, negative}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(64'd100, 64'd7, lat);
        chk("basic_latency", lat, 64'd64);
        chk("basic_quotient", quotient, 64'd14);
        chk("basic_remainder", remainder, 64'd2);
        chk("basic_zero", {63'd0, zero}, 64'd0);
        chk("basic_negative", {63'd0, negative}, 64'd0);
        chk("basic_div_zero", {63'd0, div_zero}, 64'd0);

        run_op(64'd5, 64'd9, lat);
        chk("small_quotient", quotient, 64'd0);
        chk("small_remainder", remainder, 64'd5);
        chk("small_zero", {63'd0, zero}, 64'd1);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
        chk("max_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("max_remainder", remainder, 64'd0);
        chk("max_negative", {63'd0, negative}, 64'd1);

        run_op(64'h1234, 64'd0, lat);
        chk("dz_latency", lat, 64'd0);
        chk("dz_div_zero", {63'd0, div_zero}, 64'd1);
        chk("dz_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_remainder", remainder, 64'h1234);
        chk("dz_busy", {63'd0, busy}, 64'd0);

        // Second start mid-run must not disturb the first operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 64'd1000;
        divisor  = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
        repeat (20) @(negedge clk);
        start    = 1'b1;
        dividend = 64'd77;
        divisor  = 64'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, lat);
        chk("ignore_latency", lat, 64'd64);
        chk("ignore_quotient", quotient, 64'd333);
        chk("ignore_remainder", remainder, 64'd1);
        chk("ignore_div_zero", {63'd0, div_zero}, 64'd0);

        // Reset at iteration 30, with a start attempt held during reset.
        @(negedge clk);
        start    = 1'b1;
        dividend = 64'd100;
        divisor  = 64'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        start    = 1'b1;
        dividend = 64'd55;
        divisor  = 64'd0;
        @(posedge clk);
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_quotient", quotient, 64'd0);
        chk("abort_remainder", remainder, 64'd0);
        chk("abort_div_zero", {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        run_op(64'd100, 64'd7, lat);
        chk("post_rst_latency", lat, 64'd64);
        chk("post_rst_quotient", quotient, 64'd14);
        chk("post_rst_remainder", remainder, 64'd2);

        // Random traffic: starts arrive in every state, occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 599) != 0);
            start    = ($urandom_range(0, 2) == 0);
            dividend = rnd();
            divisor  = ($urandom_range(0, 15) == 0) ? 64'd0 : rnd();
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (70) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
